fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised multi-lane instruction queue between the I-cache fetch stage and the per-lane decoders. Accepts one fetch bundle of `LANES` 32-bit instructions per cycle, stores up to `DEPTH` bundles, and presents the head bundle on `LANES` independent output lanes with per-lane valid/accept handshakes. It masks lanes below the fetch start offset and lanes above a predicted-taken lane, and enforces in-order consumption within a bundle. A flush discards all contents in one cycle.

## Interface
- `LANES`, default 2: instructions per bundle; power of 2, ≥2. `LB` = log2(`LANES`).
- `DEPTH`, default 4: bundle entries; power of 2, ≥2.
- `INFO_W`, default 2: per-bundle sideband width ({fault_page, fault_fetch}).
- `clk_i`  in  1  clock.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  branch-mispredict flush.
- `in_valid_i`  in  1  bundle valid.
- `in_accept_o`  out  1  queue can take a bundle.
- `in_instr_i`  in  LANES*32  lane k in bits [32k+31:32k].
- `in_pc_i`  in  32  fetch PC.
- `in_info_i`  in  INFO_W  fault sideband; nonzero = faulted bundle.
- `in_pred_i`  in  LANES  bit k = lane k predicted taken.
- `out_valid_o`  out  LANES  per-lane valid.
- `out_accept_i`  in  LANES  per-lane accept.
- `out_instr_o`  out  LANES*32  head instructions.
- `out_pc_o`  out  LANES*32  lane k PC = {pc[31:LB+2], k[LB-1:0], 2'b00}.
- `out_info_o`  out  INFO_W  head sideband.
- `level_o`  out  log2(DEPTH)+1  occupied entries.

## Operation
- Start lane s = `in_pc_i[LB+1:2]`. Pred bits on lanes < s are ignored. t = lowest lane ≥ s with pred set, else `LANES-1`.
- Stored lane mask: lane k valid iff s ≤ k ≤ t. The mask always has ≥1 bit set.
- Faulted bundle (`in_info_i` != 0): instruction data stored as all zeros; mask = lane s only. This delivers exactly one fault.
- Push when `in_valid_i & in_accept_o`: write instr, pc, info and mask at `wr_ptr`; `wr_ptr` wraps modulo `DEPTH`.
- `in_accept_o` = (level != DEPTH). A push is not accepted when full, even if a pop occurs in the same cycle.
- `out_valid_o[k]` = (level != 0) & mask[head][k].
- In-order rule: lane k is consumed only if `out_valid_o[k] & out_accept_i[k]` and every lower lane j < k is either already clear in the mask or consumed in the same cycle. An accept that violates the rule is ignored and the lane stays valid.
- Consumed lanes clear in the head mask. When all remaining set bits are consumed, the entry pops: `rd_ptr`+1 modulo `DEPTH`.
- level: +1 on push without pop, −1 on pop without push, unchanged when both or neither occur.
- `flush_i` has priority over push and pop: level, pointers and all masks go to 0, and any push that cycle is dropped.

## Timing
- Reset: all outputs 0 except `in_accept_o`=1. Pointers, level and masks are 0; data registers are 0.
- Push-to-output latency is 1 cycle (without bypass): a bundle pushed at edge N is visible after edge N.
- A pop at edge N exposes the next entry in the same cycle after N. Back-to-back full-bandwidth operation is possible at DEPTH ≥ 2.
- Flush asserted in cycle N: from edge N, `out_valid_o` = 0 and `in_accept_o` = 1.
- Reset asserted mid-operation clears state immediately and asynchronously.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined: when level = 0, `in_valid_i` = 1 and `flush_i` = 0, the outputs present the input bundle combinationally, with its mask computed as above.
  - Lanes accepted in that cycle are consumed.
  - If every masked lane is consumed, nothing is written.
  - Otherwise the bundle is written with the remaining mask.
  - Latency becomes 0.
- Not defined: no bypass; 1-cycle latency as specified above.

## Test plan
- LANES=2, DEPTH=4, push pc=0x1000, instrs {0x00B00093, 0x00100113}, pred=0, both accepts high one cycle later -> both lanes valid, PCs 0x1000/0x1004, entry pops, level returns to 0.
- Push pc=0x1004 (s=1), pred=2'b00 -> only lane 1 valid with PC 0x1004; accepting lane 1 pops the entry.
- Push pc=0x2000, pred=2'b01 -> lane 0 only. Assert `out_accept_i`=2'b10 with lane 0 pending in another bundle -> lane 1 accept ignored, no pop.
- Push 4 bundles with no accepts -> level=4, `in_accept_o`=0. Fifth `in_valid_i` held -> not accepted until one pop; pointers wrap 3→0 correctly.
- Fill 3 entries, then `flush_i` with simultaneous push -> next cycle level=0, all `out_valid_o`=0, pushed bundle absent.
- Faulted push, `in_info_i`=2'b10, pc=0x3004 -> lane 1 valid only, instr 0, `out_info_o`=2'b10.

Source files
------------

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - multi-lane fetch bundle queue with per-lane in-order consumption.
// Optional combinational bypass on an empty queue: FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int LANES  = 2,
    parameter int DEPTH  = 4,
    parameter int INFO_W = 2
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          flush_i,
    input  logic                          in_valid_i,
    output logic                          in_accept_o,
    input  logic [LANES*32-1:0]           in_instr_i,
    input  logic [31:0]                   in_pc_i,
    input  logic [INFO_W-1:0]             in_info_i,
    input  logic [LANES-1:0]              in_pred_i,
    output logic [LANES-1:0]              out_valid_o,
    input  logic [LANES-1:0]              out_accept_i,
    output logic [LANES*32-1:0]           out_instr_o,
    output logic [LANES*32-1:0]           out_pc_o,
    output logic [INFO_W-1:0]             out_info_o,
    output logic [$clog2(DEPTH):0]        level_o
);
    localparam int LB = $clog2(LANES);
    localparam int DW = $clog2(DEPTH);

    logic [LANES*32-1:0] instr_q [DEPTH];
    logic [31:0]         pc_q    [DEPTH];
    logic [INFO_W-1:0]   info_q  [DEPTH];
    logic [LANES-1:0]    mask_q  [DEPTH];

    logic [DW-1:0] wr_ptr_q, wr_ptr_d;
    logic [DW-1:0] rd_ptr_q, rd_ptr_d;
    logic [DW:0]   level_q, level_d;

    logic [LB-1:0]       start_lane;
    logic [LB-1:0]       stop_lane;
    logic                in_fault;
    logic [LANES-1:0]    in_mask;
    logic [LANES*32-1:0] in_data;

    logic                q_empty;
    logic                q_full;
    logic                bypass;
    logic                head_valid;
    logic [LANES-1:0]    head_mask;
    logic [LANES*32-1:0] head_data;
    logic [31:0]         head_pc;
    logic [INFO_W-1:0]   head_info;
    logic [LANES-1:0]    consume;
    logic [LANES-1:0]    remaining;
    logic                pop;
    logic                push_ok;
    logic                write;
    logic [LANES-1:0]    write_mask;
    logic                unused_pc_bits;

    // Lane window of an incoming bundle: start lane up to the first taken prediction.
    always_comb begin
        start_lane = in_pc_i[LB+1:2];
        in_fault   = |in_info_i;
        stop_lane  = LB'(LANES - 1);
        for (int k = LANES - 1; k >= 0; k--) begin
            if ((LB'(k) >= start_lane) && in_pred_i[k]) begin
                stop_lane = LB'(k);
            end
        end
        in_mask = '0;
        for (int k = 0; k < LANES; k++) begin
            if (in_fault) begin
                in_mask[k] = (LB'(k) == start_lane);
            end else begin
                in_mask[k] = (LB'(k) >= start_lane) && (LB'(k) <= stop_lane);
            end
        end
        in_data = in_fault ? '0 : in_instr_i;
    end

    assign q_empty = (level_q == '0);
    assign q_full  = (level_q == (DW+1)'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = q_empty & in_valid_i & ~flush_i;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        head_valid = ~q_empty | bypass;
        if (bypass) begin
            head_mask = in_mask;
            head_data = in_data;
            head_pc   = in_pc_i;
            head_info = in_info_i;
        end else begin
            head_mask = mask_q[rd_ptr_q];
            head_data = instr_q[rd_ptr_q];
            head_pc   = pc_q[rd_ptr_q];
            head_info = info_q[rd_ptr_q];
        end
    end

    // A lane is taken only once every lower still-pending lane goes with it.
    always_comb begin
        logic lower_done;
        lower_done = 1'b1;
        consume    = '0;
        for (int k = 0; k < LANES; k++) begin
            consume[k] = head_valid & head_mask[k] & out_accept_i[k] & lower_done;
            lower_done = lower_done & (~head_mask[k] | consume[k]);
        end
        remaining = head_mask & ~consume;
    end

    assign pop        = ~q_empty & (remaining == '0);
    assign push_ok    = in_valid_i & in_accept_o & ~flush_i;
    assign write      = push_ok & (~bypass | (remaining != '0));
    assign write_mask = bypass ? remaining : in_mask;

    always_comb begin
        level_d  = level_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            level_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (write) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (write && !pop) begin
                level_d = level_q + 1'b1;
            end else if (pop && !write) begin
                level_d = level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
                info_q[i]  <= '0;
                mask_q[i]  <= '0;
            end
        end else begin
            level_q  <= level_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (flush_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mask_q[i] <= '0;
                end
            end else begin
                // Head and write slots only coincide when empty or full, never both active.
                if (!q_empty) begin
                    mask_q[rd_ptr_q] <= remaining;
                end
                if (write) begin
                    mask_q[wr_ptr_q]  <= write_mask;
                    instr_q[wr_ptr_q] <= in_data;
                    pc_q[wr_ptr_q]    <= in_pc_i;
                    info_q[wr_ptr_q]  <= in_info_i;
                end
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign out_valid_o[k]          = head_valid & head_mask[k];
        assign out_instr_o[k*32 +: 32] = head_valid ? head_data[k*32 +: 32] : 32'd0;
        assign out_pc_o[k*32 +: 32]    = head_valid ? {head_pc[31:LB+2], LB'(k), 2'b00} : 32'd0;
    end

    assign unused_pc_bits = ^head_pc[LB+1:0];
    assign out_info_o     = head_valid ? head_info : '0;
    assign in_accept_o    = ~q_full;
    assign level_o        = level_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized and directed check of fetch_queue against a queue-based model.
module tb_fetch_queue;
    localparam int L  = 2;
    localparam int D  = 4;
    localparam int IW = 2;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          flush_i;
    logic          in_valid_i;
    logic          in_accept_o;
    logic [L*32-1:0] in_instr_i;
    logic [31:0]   in_pc_i;
    logic [IW-1:0] in_info_i;
    logic [L-1:0]  in_pred_i;
    logic [L-1:0]  out_valid_o;
    logic [L-1:0]  out_accept_i;
    logic [L*32-1:0] out_instr_o;
    logic [L*32-1:0] out_pc_o;
    logic [IW-1:0] out_info_o;
    logic [2:0]    level_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [L*32-1:0] ins;
        logic [31:0]     pc;
        logic [IW-1:0]   info;
        logic [L-1:0]    mask;
    } ent_t;

    ent_t q[$];

    always #5 clk_i = ~clk_i;

    fetch_queue #(.LANES(L), .DEPTH(D), .INFO_W(IW)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_accept_o  (in_accept_o),
        .in_instr_i   (in_instr_i),
        .in_pc_i      (in_pc_i),
        .in_info_i    (in_info_i),
        .in_pred_i    (in_pred_i),
        .out_valid_o  (out_valid_o),
        .out_accept_i (out_accept_i),
        .out_instr_o  (out_instr_o),
        .out_pc_o     (out_pc_o),
        .out_info_o   (out_info_o),
        .level_o      (level_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] pc, input logic [L*32-1:0] ins,
                                input logic [IW-1:0] info, input logic [L-1:0] pred);
        ent_t e;
        int   s;
        int   t;
        bit   found;
        e     = '0;
        s     = int'((pc >> 2) % L);
        t     = L - 1;
        found = 1'b0;
        for (int k = s; k < L; k++) begin
            if (pred[k] && !found) begin
                t     = k;
                found = 1'b1;
            end
        end
        e.pc   = pc;
        e.info = info;
        if (info != 0) begin
            e.ins     = '0;
            e.mask[s] = 1'b1;
        end else begin
            e.ins = ins;
            for (int k = s; k <= t; k++) e.mask[k] = 1'b1;
        end
        return e;
    endfunction

    // Drive one cycle, compare mid-cycle against the model, then advance the model.
    task automatic step(input logic v, input logic [31:0] pc, input logic [L*32-1:0] ins,
                        input logic [IW-1:0] info, input logic [L-1:0] pred,
                        input logic [L-1:0] acc, input logic fl);
        ent_t h;
        ent_t nb;
        bit   hv;
        bit   byp;
        bit   stop;
        int   pre;
        logic [L-1:0] rem;
        in_valid_i   = v;
        in_pc_i      = pc;
        in_instr_i   = ins;
        in_info_i    = info;
        in_pred_i    = pred;
        out_accept_i = acc;
        flush_i      = fl;
        @(negedge clk_i);
        pre = q.size();
        hv  = (pre > 0);
        byp = 1'b0;
        h   = '0;
        nb  = mk(pc, ins, info, pred);
        if (hv) h = q[0];
`ifdef FETCH_QUEUE_BYPASS_EN
        if (!hv && v && !fl) begin
            h   = nb;
            hv  = 1'b1;
            byp = 1'b1;
        end
`endif
        check("out_valid", 32'(out_valid_o), 32'(hv ? h.mask : '0));
        check("in_accept", 32'(in_accept_o), 32'(pre != D));
        check("level", 32'(level_o), 32'(pre));
        check("out_info", 32'(out_info_o), 32'(hv ? h.info : '0));
        for (int k = 0; k < L; k++) begin
            check($sformatf("instr%0d", k), out_instr_o[k*32 +: 32], hv ? h.ins[k*32 +: 32] : 32'd0);
            check($sformatf("pc%0d", k), out_pc_o[k*32 +: 32],
                  hv ? 32'(h.pc - (h.pc % (L*4)) + k*4) : 32'd0);
        end
        rem  = hv ? h.mask : '0;
        stop = 1'b0;
        for (int k = 0; k < L; k++) begin
            if (rem[k] && !stop) begin
                if (acc[k]) rem[k] = 1'b0;
                else stop = 1'b1;
            end
        end
        if (fl) begin
            q.delete();
        end else if (byp) begin
            if (rem != 0) begin
                nb.mask = rem;
                q.push_back(nb);
            end
        end else begin
            if (hv) begin
                if (rem == 0) begin
                    void'(q.pop_front());
                end else begin
                    h.mask = rem;
                    q[0]   = h;
                end
            end
            if (v && pre < D) q.push_back(nb);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input logic [L-1:0] acc);
        step(1'b0, 32'h0, '0, '0, '0, acc, 1'b0);
    endtask

    task automatic mid_reset();
        in_valid_i   = 1'b0;
        flush_i      = 1'b0;
        out_accept_i = '0;
        #2;
        rstn_i = 1'b0;
        #1;
        check("rst_level", 32'(level_o), 32'd0);
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_accept", 32'(in_accept_o), 32'd1);
        q.delete();
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    localparam logic [63:0] INS_A = {32'h00100113, 32'h00B00093};

    initial begin
        rstn_i       = 1'b0;
        flush_i      = 1'b0;
        in_valid_i   = 1'b0;
        in_instr_i   = '0;
        in_pc_i      = '0;
        in_info_i    = '0;
        in_pred_i    = '0;
        out_accept_i = '0;
        #2;
        check("reset_valid", 32'(out_valid_o), 32'd0);
        check("reset_accept", 32'(in_accept_o), 32'd1);
        check("reset_level", 32'(level_o), 32'd0);
        check("reset_instr", out_instr_o[31:0] | out_instr_o[63:32], 32'd0);
        check("reset_pc", out_pc_o[31:0] | out_pc_o[63:32], 32'd0);
        check("reset_info", 32'(out_info_o), 32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Full bundle, both lanes consumed together.
        step(1'b1, 32'h1000, INS_A, 2'b00, 2'b00, 2'b00, 1'b0);
        idle(2'b11);
        idle(2'b00);
        // Start offset masks lane 0.
        step(1'b1, 32'h1004, INS_A, 2'b00, 2'b00, 2'b00, 1'b0);
        idle(2'b10);
        idle(2'b00);
        // Taken prediction on lane 0, then out-of-order accept on a full bundle.
        step(1'b1, 32'h2000, INS_A, 2'b00, 2'b01, 2'b00, 1'b0);
        step(1'b1, 32'h2008, INS_A, 2'b00, 2'b00, 2'b10, 1'b0);
        idle(2'b01);
        idle(2'b10);
        idle(2'b01);
        idle(2'b10);
        idle(2'b00);
        // Fill, hold a fifth bundle while full, then drain across the pointer wrap.
        for (int i = 0; i < 4; i++) step(1'b1, 32'h4000 + 32'(i*8), {$urandom, $urandom}, 2'b00, 2'b00, 2'b00, 1'b0);
        step(1'b1, 32'h5000, INS_A, 2'b00, 2'b00, 2'b00, 1'b0);
        step(1'b1, 32'h5000, INS_A, 2'b00, 2'b00, 2'b11, 1'b0);
        step(1'b1, 32'h5000, INS_A, 2'b00, 2'b00, 2'b00, 1'b0);
        for (int i = 0; i < 5; i++) idle(2'b11);
        // Flush with a simultaneous push.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h6000 + 32'(i*8), {$urandom, $urandom}, 2'b00, 2'b00, 2'b00, 1'b0);
        step(1'b1, 32'h7000, INS_A, 2'b00, 2'b00, 2'b00, 1'b1);
        idle(2'b00);
        // Faulted bundle delivers only its start lane with zero data.
        step(1'b1, 32'h3004, INS_A, 2'b10, 2'b00, 2'b00, 1'b0);
        idle(2'b00);
        idle(2'b11);
        idle(2'b00);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7,
                 $urandom & 32'hFFFF_FFFC,
                 {$urandom, $urandom},
                 ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                 ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
                 ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom),
                 $urandom_range(0, 39) == 0);
            if (i == 1500) mid_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
